// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the command decode, the counter
// sequencer and the counter datapath register.
interface counter_seq_ctrl_if #(
  parameter int CW = 8,
  parameter int PW = 4
);
  // commands and start-time configuration
  logic          cmd_start;
  logic          cmd_stop;
  logic          cmd_clear;
  logic          oneshot;
  logic [PW-1:0] prescale;
  logic [CW-1:0] limit;
  // value returned by the counter datapath
  logic [CW-1:0] count;
  // strobes and status produced by the sequencer
  logic          cnt_inc;
  logic          cnt_clr;
  logic          busy;
  logic          done;
  logic          wrap_pulse;
  logic [CW-1:0] period_cnt;
  logic [1:0]    state;

  // command/datapath side
  modport master (
    output cmd_start, cmd_stop, cmd_clear, oneshot, prescale, limit, count,
    input  cnt_inc, cnt_clr, busy, done, wrap_pulse, period_cnt, state
  );

  // sequencer side
  modport slave (
    input  cmd_start, cmd_stop, cmd_clear, oneshot, prescale, limit, count,
    output cnt_inc, cnt_clr, busy, done, wrap_pulse, period_cnt, state
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Counter sequencer: turns start/stop/clear commands into per-cycle
// increment/clear strobes for the counter datapath, with a prescaler,
// a terminal-count limit, one-shot or periodic operation and a
// saturating count of completed periods.
module counter_seq_ctrl #(
  parameter int CW = 8,
  parameter int PW = 4
) (
  input logic             clk,
  input logic             rst_n,
  counter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [CW-1:0] PERIOD_MAX = '1;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_cnt_reg, presc_cnt_next;
  logic [CW-1:0] period_cnt_reg, period_cnt_next;

  // configuration shadows, only refreshed by a start from IDLE/DONE
  logic          sh_oneshot_reg;
  logic [PW-1:0] sh_prescale_reg;
  logic [CW-1:0] sh_limit_reg;
  logic          capture;

  logic          tick;
  logic          at_limit;
  logic          inc;
  logic          clr;
  logic          wrap;

  assign tick     = (presc_cnt_reg == sh_prescale_reg);
  assign at_limit = (bus.count == sh_limit_reg);

  // Next-state and strobe decode; clear beats stop beats start.
  always_comb begin
    state_next      = state_reg;
    presc_cnt_next  = presc_cnt_reg;
    period_cnt_next = period_cnt_reg;
    capture         = 1'b0;
    inc             = 1'b0;
    clr             = 1'b0;
    wrap            = 1'b0;

    if (bus.cmd_clear) begin
      state_next      = IDLE;
      clr             = 1'b1;
      presc_cnt_next  = '0;
      period_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // a concurrent stop blocks the start even though stop itself
          // does nothing here
          if (!bus.cmd_stop && bus.cmd_start) begin
            state_next      = RUN;
            capture         = 1'b1;
            clr             = 1'b1;
            presc_cnt_next  = '0;
            period_cnt_next = '0;
          end
        end

        RUN: begin
          if (bus.cmd_stop) begin
            // pause without advancing the prescaler so a resume keeps phase
            state_next = HOLD;
          end else if (tick) begin
            presc_cnt_next = '0;
            if (!at_limit) begin
              // also covers count above the limit: keep counting until
              // the datapath wraps round to it
              inc = 1'b1;
            end else if (!sh_oneshot_reg) begin
              clr  = 1'b1;
              wrap = 1'b1;
              if (period_cnt_reg != PERIOD_MAX) begin
                period_cnt_next = period_cnt_reg + 1'b1;
              end
            end else begin
              state_next = DONE;
            end
          end else begin
            presc_cnt_next = presc_cnt_reg + 1'b1;
          end
        end

        HOLD: begin
          // resume keeps shadows and prescaler phase, no counter clear
          if (!bus.cmd_stop && bus.cmd_start) begin
            state_next = RUN;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, prescaler and period counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      presc_cnt_reg  <= '0;
      period_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      presc_cnt_reg  <= presc_cnt_next;
      period_cnt_reg <= period_cnt_next;
    end
  end

  // Configuration shadows, captured only on a fresh start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_oneshot_reg  <= 1'b0;
      sh_prescale_reg <= '0;
      sh_limit_reg    <= '0;
    end else if (capture) begin
      sh_oneshot_reg  <= bus.oneshot;
      sh_prescale_reg <= bus.prescale;
      sh_limit_reg    <= bus.limit;
    end
  end

  assign bus.cnt_inc    = inc;
  assign bus.cnt_clr    = clr;
  assign bus.wrap_pulse = wrap;
  assign bus.busy       = (state_reg == RUN);
  assign bus.done       = (state_reg == DONE);
  assign bus.period_cnt = period_cnt_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for the counter sequencer, with a behavioural counter
// register standing in for the datapath.
module tb_counter_seq_ctrl;

  logic clk;
  logic rst_n;
  int   check_cnt;
  int   err_cnt;

  counter_seq_ctrl_if #(.CW(8), .PW(4)) bus ();

  counter_seq_ctrl #(.CW(8), .PW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counter datapath: clear has priority over increment
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            bus.count <= 8'd0;
    else if (bus.cnt_clr)  bus.count <= 8'd0;
    else if (bus.cnt_inc)  bus.count <= bus.count + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // move to 1 time unit after the next rising edge (input drive point)
  task automatic go;
    @(posedge clk);
    #1;
  endtask

  initial begin
    check_cnt     = 0;
    err_cnt       = 0;
    rst_n         = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.oneshot   = 1'b0;
    bus.prescale  = 4'd0;
    bus.limit     = 8'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_inc", 32'(bus.cnt_inc), 32'd0);
    chk("rst_clr", 32'(bus.cnt_clr), 32'd0);
    chk("rst_wrap", 32'(bus.wrap_pulse), 32'd0);
    chk("rst_period", 32'(bus.period_cnt), 32'd0);
    rst_n = 1'b1;

    // one-shot, prescale 3, limit 5
    bus.prescale  = 4'd3;
    bus.limit     = 8'd5;
    bus.oneshot   = 1'b1;
    bus.cmd_start = 1'b1;
    #2;
    chk("t2_start_clr", 32'(bus.cnt_clr), 32'd1);
    chk("t2_start_state", 32'(bus.state), 32'd0);
    go;
    bus.cmd_start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #2;
      chk($sformatf("t2_inc_k%0d", k), 32'(bus.cnt_inc), ((k % 4 == 3) && (k < 20)) ? 32'd1 : 32'd0);
      chk($sformatf("t2_count_k%0d", k), 32'(bus.count), (k / 4 > 5) ? 32'd5 : 32'(k / 4));
      go;
    end
    #2;
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_state", 32'(bus.state), 32'd3);
    chk("t2_busy", 32'(bus.busy), 32'd0);
    chk("t2_count", 32'(bus.count), 32'd5);
    for (int i = 0; i < 3; i++) begin
      go;
      #2;
      chk("t2_hold_count", 32'(bus.count), 32'd5);
      chk("t2_hold_inc", 32'(bus.cnt_inc), 32'd0);
    end

    // periodic, prescale 0, limit 2, restarted from DONE
    bus.prescale  = 4'd0;
    bus.limit     = 8'd2;
    bus.oneshot   = 1'b0;
    bus.cmd_start = 1'b1;
    #2;
    chk("t3_start_clr", 32'(bus.cnt_clr), 32'd1);
    go;
    bus.cmd_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #2;
      chk($sformatf("t3_count_k%0d", k), 32'(bus.count), 32'(k % 3));
      chk($sformatf("t3_inc_k%0d", k), 32'(bus.cnt_inc), (k % 3 != 2) ? 32'd1 : 32'd0);
      chk($sformatf("t3_wrap_k%0d", k), 32'(bus.wrap_pulse), (k % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("t3_period_k%0d", k), 32'(bus.period_cnt), 32'(k / 3));
      go;
    end
    #2;
    chk("t3_period_end", 32'(bus.period_cnt), 32'd3);
    chk("t3_count_end", 32'(bus.count), 32'd0);

    // clear from RUN
    bus.cmd_clear = 1'b1;
    #2;
    chk("clr_strobe", 32'(bus.cnt_clr), 32'd1);
    go;
    bus.cmd_clear = 1'b0;
    #2;
    chk("clr_state", 32'(bus.state), 32'd0);
    chk("clr_period", 32'(bus.period_cnt), 32'd0);
    chk("clr_count", 32'(bus.count), 32'd0);

    // hold and resume keep prescaler phase
    bus.prescale  = 4'd3;
    bus.limit     = 8'd9;
    bus.oneshot   = 1'b0;
    bus.cmd_start = 1'b1;
    #2;
    go;
    bus.cmd_start = 1'b0;
    repeat (6) go;
    bus.cmd_stop = 1'b1;
    #2;
    chk("t4_stop_inc", 32'(bus.cnt_inc), 32'd0);
    chk("t4_stop_state", 32'(bus.state), 32'd1);
    chk("t4_stop_count", 32'(bus.count), 32'd1);
    go;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("t4_hold_state_%0d", i), 32'(bus.state), 32'd2);
      chk($sformatf("t4_hold_count_%0d", i), 32'(bus.count), 32'd1);
      chk($sformatf("t4_hold_inc_%0d", i), 32'(bus.cnt_inc), 32'd0);
      go;
    end
    bus.cmd_stop  = 1'b0;
    bus.cmd_start = 1'b1;
    #2;
    chk("t4_resume_clr", 32'(bus.cnt_clr), 32'd0);
    chk("t4_resume_inc", 32'(bus.cnt_inc), 32'd0);
    go;
    bus.cmd_start = 1'b0;
    #2;
    chk("t4_run0_state", 32'(bus.state), 32'd1);
    chk("t4_run0_inc", 32'(bus.cnt_inc), 32'd0);
    go;
    #2;
    chk("t4_run1_inc", 32'(bus.cnt_inc), 32'd1);
    go;
    #2;
    chk("t4_count_after", 32'(bus.count), 32'd2);

    // all three commands together: clear wins
    bus.cmd_start = 1'b1;
    bus.cmd_stop  = 1'b1;
    bus.cmd_clear = 1'b1;
    #2;
    chk("t5_all_clr", 32'(bus.cnt_clr), 32'd1);
    chk("t5_all_inc", 32'(bus.cnt_inc), 32'd0);
    go;
    bus.cmd_clear = 1'b0;
    #2;
    chk("t5_state", 32'(bus.state), 32'd0);
    chk("t5_idle_ss_clr", 32'(bus.cnt_clr), 32'd0);
    go;
    #2;
    chk("t5_idle_ss_state", 32'(bus.state), 32'd0);
    chk("t5_idle_ss_busy", 32'(bus.busy), 32'd0);
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;

    // limit 0 periodic: clear every cycle, period saturates
    bus.prescale  = 4'd0;
    bus.limit     = 8'd0;
    bus.oneshot   = 1'b0;
    bus.cmd_start = 1'b1;
    #2;
    go;
    bus.cmd_start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == 10) bus.limit = 8'd7;
      #2;
      chk($sformatf("t6_clr_k%0d", k), 32'(bus.cnt_clr), 32'd1);
      if (k == 100 || k == 254 || k == 255 || k == 299)
        chk($sformatf("t6_period_k%0d", k), 32'(bus.period_cnt), (k > 255) ? 32'd255 : 32'(k));
      go;
    end
    #2;
    chk("t6_period_sat", 32'(bus.period_cnt), 32'd255);
    chk("t6_count", 32'(bus.count), 32'd0);

    // asynchronous reset mid-RUN, no clock edge in between
    rst_n = 1'b0;
    #1;
    chk("t1_state", 32'(bus.state), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_period", 32'(bus.period_cnt), 32'd0);
    chk("t1_inc", 32'(bus.cnt_inc), 32'd0);
    chk("t1_clr", 32'(bus.cnt_clr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
